zion_ins_queue: RTL and testbench
=================================

Name: zion_ins_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched instructions with their PC and fetch-fault flag in a circular FIFO.
- Upstream side is a valid/ready port; downstream side is first-word-fall-through valid/ready.
- Supports a single-cycle flush on redirect (branch mispredict or exception), so decode sees instructions in program order and never sees wrong-path instructions after a flush.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries this cycle.
- enq_valid  in  1  fetch presents an instruction.
- enq_ready  out  1  queue can accept.
- enq_pc  in  32 (CpuType)  instruction address.
- enq_ins  in  32 (CpuIns)  instruction word.
- enq_fault  in  1  fetch access fault for this instruction.
- deq_valid  out  1  head entry is available.
- deq_ready  in  1  decode consumes the head.
- deq_pc  out  32 (CpuType)  head PC.
- deq_ins  out  32 (CpuIns)  head instruction.
- deq_fault  out  1  head fault flag.
- count  out  CNT_W  current occupancy.

Behaviour:
- State: storage array of DEPTH entries {pc, ins, fault}; wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter cnt.
- Storage is not reset. Pointers and cnt reset to 0.
- Reset/output values while rst=1 and the cycle after: enq_ready=0 during rst; deq_valid=0; deq_pc=0, deq_ins=0, deq_fault=0; count=0.
- enq_ready = !rst && (cnt != DEPTH). It does not depend on deq_ready, so there is no combinational path deq_ready→enq_ready. A full queue with a simultaneous dequeue still refuses enqueue that cycle.
- deq_valid = (cnt != 0) && !flush.
- deq_pc/deq_ins/deq_fault:
  - When deq_valid=1, they equal storage[rd_ptr].
  - Otherwise they are driven to 0.
  - Purely combinational from registered state.
- Enqueue fires when enq_valid && enq_ready && !flush: write entry at wr_ptr, then wr_ptr+1.
- Dequeue fires when deq_valid && deq_ready: rd_ptr+1.
- cnt next value:
  - +1 if enqueue only.
  - −1 if dequeue only.
  - Unchanged if both or neither.
- Latency: an instruction enqueued in cycle N is visible at deq in cycle N+1 (no same-cycle bypass, including when empty).
- Flush (priority over everything except rst):
  - Next cycle: wr_ptr=rd_ptr=0, cnt=0.
  - Any enqueue attempt in the flush cycle is dropped.
  - deq_valid=0 in the flush cycle, so no dequeue fires.
  - enq_ready may read 1 during flush, but the handshake is ignored.
- Wrap-around: pointers roll from DEPTH−1 to 0. Full versus empty is distinguished solely by cnt.
- rst mid-operation: identical effect to flush plus enq_ready=0 while asserted. Contents are discarded.
- enq_valid is not required to remain asserted if not accepted. The queue makes no assumption about upstream stability.
- Assertions (simulation only):
  - cnt ≤ DEPTH.
  - No enqueue fires when cnt == DEPTH.
  - No dequeue fires when cnt == 0.

Decomposition:
- ZionDataType gains a packed struct InsQueueEntry {CpuType pc; CpuIns ins; logic fault;}, reused by decode.
- ZionDataType gains a localparam default INS_QUEUE_DEPTH = 8.
- Sub-module: none required; the circular storage stays inline.
- Optional: a generic zion_wrap_counter (increment-mod-DEPTH pointer with clear) may be factored out and instantiated twice.

Test Plan:
- Reset then idle: hold rst 3 cycles, release → deq_valid=0, enq_ready=1, count=0, deq_ins=0.
- Basic ordering, latency and count: enqueue pc=0x1000/ins=0x00000013, pc=0x1004/ins=0x00100093 on consecutive cycles with deq_ready=0 →
  - deq_valid rises the cycle after the first enqueue.
  - Head shows 0x1000 with count=2.
  - Then deq_ready=1 for 2 cycles yields 0x1000, then 0x1004.
  - count returns to 0.
- Full/backpressure: DEPTH=8, deq_ready=0, enq_valid=1 for 10 cycles with pc=0x2000+4i →
  - enq_ready=0 after 8 accepts; count=8.
  - Entries 8–9 are held by the source.
  - Draining returns 0x2000..0x201C in order.
- Simultaneous enq/deq plus wrap: keep count=3 while streaming 20 instructions with enq and deq both firing each cycle → count stays 3, all 20 PCs emerge in order, and pointers wrap twice.
- Flush: with count=5, assert flush alongside enq_valid=1 (pc=0x3000) and deq_ready=1 →
  - deq_valid=0 that cycle, and no dequeue occurs.
  - Next cycle count=0 and deq_valid=0; 0x3000 never appears.
  - A following enqueue of 0x4000 appears one cycle later.
- Fault propagation and rst mid-stream:
  - Enqueue pc=0x5000 with enq_fault=1 → deq_fault=1 only with that entry.
  - Asserting rst with count=4 → count=0 next cycle, and no stale entry is seen after release.

Source files
------------

// File: rtl/zion_ins_queue_pkg.sv
// Shared fetch/decode data types and instruction-queue defaults.
package zion_ins_queue_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned INS_QUEUE_DEPTH = 8;

    typedef logic [XLEN-1:0] cpu_type_t;
    typedef logic [31:0]     cpu_ins_t;

    typedef struct packed {
        cpu_type_t pc;
        cpu_ins_t  ins;
        logic      fault;
    } ins_queue_entry_t;

endpackage

// File: rtl/zion_ins_queue_wrap_counter.sv
// Pointer that increments modulo DEPTH, with synchronous clear.
module zion_ins_queue_wrap_counter #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= (r_value == W'(DEPTH - 1)) ? '0 : r_value + W'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/zion_ins_queue.sv
// Fetch-to-decode instruction FIFO: valid/ready in, first-word-fall-through out,
// single-cycle flush on redirect.
module zion_ins_queue
    import zion_ins_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = INS_QUEUE_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  cpu_type_t        enq_pc,
    input  cpu_ins_t         enq_ins,
    input  logic             enq_fault,
    output logic             deq_valid,
    input  logic             deq_ready,
    output cpu_type_t        deq_pc,
    output cpu_ins_t         deq_ins,
    output logic             deq_fault,
    output logic [CNT_W-1:0] count
);

    ins_queue_entry_t   r_mem [DEPTH];
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_deq;
    ins_queue_entry_t   w_head;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Ready ignores deq_ready on purpose: no deq_ready -> enq_ready path.
    assign enq_ready = !rst && !w_full;
    assign deq_valid = !w_empty && !flush && !rst;

    assign w_enq = enq_valid && enq_ready && !flush;
    assign w_deq = deq_valid && deq_ready;

    zion_ins_queue_wrap_counter #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_inc   (w_enq),
        .o_value (w_wr_ptr)
    );

    zion_ins_queue_wrap_counter #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_inc   (w_deq),
        .o_value (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_cnt <= '0;
        end else if (w_enq && !w_deq) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_deq && !w_enq) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[w_wr_ptr] <= '{pc: enq_pc, ins: enq_ins, fault: enq_fault};
        end
    end

    assign w_head    = r_mem[w_rd_ptr];
    assign deq_pc    = deq_valid ? w_head.pc    : '0;
    assign deq_ins   = deq_valid ? w_head.ins   : '0;
    assign deq_fault = deq_valid ? w_head.fault : 1'b0;
    assign count     = r_cnt;

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= CNT_W'(DEPTH));
    a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(w_enq && w_full));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(w_deq && w_empty));

endmodule

// File: tb/tb_zion_ins_queue.sv
// Directed bench for zion_ins_queue with a queue-based reference model checked every cycle.
module tb_zion_ins_queue;
    import zion_ins_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    cpu_type_t        enq_pc = '0;
    cpu_ins_t         enq_ins = '0;
    logic             enq_fault = 1'b0;
    logic             deq_valid;
    logic             deq_ready = 1'b0;
    cpu_type_t        deq_pc;
    cpu_ins_t         deq_ins;
    logic             deq_fault;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    ins_queue_entry_t model_q[$];
    logic [32:0]      got[$];     // {fault, pc} of every dequeue the DUT performed
    bit               model_live = 1'b0;

    zion_ins_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_ins   (enq_ins),
        .enq_fault (enq_fault),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_ins   (deq_ins),
        .deq_fault (deq_fault),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs follow from queue occupancy; updates applied on the edge.
    initial begin : model
        bit               do_enq, do_deq, do_clr;
        bit               e_rdy, e_vld;
        ins_queue_entry_t e_head, new_e;
        forever begin
            @(negedge clk);
            e_rdy  = !rst && (model_q.size() != DEPTH);
            e_vld  = (model_q.size() != 0) && !flush && !rst;
            e_head = e_vld ? model_q[0] : '0;
            if (model_live) begin
                chk("enq_ready", 64'(enq_ready), 64'(e_rdy));
                chk("deq_valid", 64'(deq_valid), 64'(e_vld));
                chk("count", 64'(count), 64'(model_q.size()));
                chk("deq_pc", 64'(deq_pc), 64'(e_head.pc));
                chk("deq_ins", 64'(deq_ins), 64'(e_head.ins));
                chk("deq_fault", 64'(deq_fault), 64'(e_head.fault));
            end
            if (deq_valid && deq_ready) got.push_back({deq_fault, deq_pc});
            do_clr = rst || flush;
            do_deq = e_vld && deq_ready;
            do_enq = enq_valid && e_rdy && !flush;
            new_e  = '{pc: enq_pc, ins: enq_ins, fault: enq_fault};
            @(posedge clk);
            if (rst) model_live = 1'b1;
            if (do_clr) begin
                model_q.delete();
            end else begin
                if (do_deq) void'(model_q.pop_front());
                if (do_enq) model_q.push_back(new_e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic set_enq(input bit v, input logic [31:0] pc, input bit f);
        enq_valid = v;
        enq_pc    = pc;
        enq_ins   = ~pc;
        enq_fault = f;
    endtask

    initial begin : stim
        int idx;
        bit acc;

        // Reset then idle
        repeat (3) cyc();
        rst = 1'b0;
        look();
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_ins", 64'(deq_ins), 64'd0);

        // Ordering and latency
        cyc();
        enq_valid = 1'b1; enq_pc = 32'h1000; enq_ins = 32'h00000013;
        look();
        chk("lat_no_bypass", 64'(deq_valid), 64'd0);
        cyc();
        enq_pc = 32'h1004; enq_ins = 32'h00100093;
        look();
        chk("lat_valid", 64'(deq_valid), 64'd1);
        chk("lat_head_ins", 64'(deq_ins), 64'h00000013);
        cyc();
        enq_valid = 1'b0;
        look();
        chk("ord_head", 64'(deq_pc), 64'h1000);
        chk("ord_count2", 64'(count), 64'd2);
        got.delete();
        cyc();
        deq_ready = 1'b1;
        repeat (2) cyc();
        deq_ready = 1'b0;
        look();
        chk("ord_count0", 64'(count), 64'd0);
        chk("ord_n", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("ord_first", 64'(got[0][31:0]), 64'h1000);
            chk("ord_second", 64'(got[1][31:0]), 64'h1004);
        end

        // Full and backpressure
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            set_enq(1'b1, 32'h2000 + 32'(4 * idx), 1'b0);
            look();
            acc = enq_ready;
            if (acc) idx++;
        end
        cyc();
        set_enq(1'b0, 32'h0, 1'b0);
        look();
        chk("full_accepts", 64'(idx), 64'd8);
        chk("full_count", 64'(count), 64'd8);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        got.delete();
        cyc();
        deq_ready = 1'b1;
        repeat (8) cyc();
        deq_ready = 1'b0;
        look();
        chk("full_drain_n", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("full_drain_pc", 64'(got[i][31:0]), 64'h2000 + 64'(4 * i));

        // Streaming at constant occupancy with wrap
        got.delete();
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_enq(1'b1, 32'h6000 + 32'(4 * k), 1'b0);
        end
        for (int k = 3; k < 23; k++) begin
            cyc();
            set_enq(1'b1, 32'h6000 + 32'(4 * k), 1'b0);
            deq_ready = 1'b1;
            look();
            chk("stream_count", 64'(count), 64'd3);
        end
        cyc();
        set_enq(1'b0, 32'h0, 1'b0);
        repeat (3) cyc();
        deq_ready = 1'b0;
        look();
        chk("stream_n", 64'(got.size()), 64'd23);
        for (int i = 0; i < 23 && i < got.size(); i++)
            chk("stream_pc", 64'(got[i][31:0]), 64'h6000 + 64'(4 * i));

        // Flush with concurrent enqueue and dequeue request
        got.delete();
        for (int k = 0; k < 5; k++) begin
            cyc();
            set_enq(1'b1, 32'h7000 + 32'(4 * k), 1'b0);
        end
        cyc();
        set_enq(1'b1, 32'h3000, 1'b0);
        flush = 1'b1;
        deq_ready = 1'b1;
        look();
        chk("flush_pre_count", 64'(count), 64'd5);
        chk("flush_deq_valid", 64'(deq_valid), 64'd0);
        cyc();
        flush = 1'b0;
        deq_ready = 1'b0;
        set_enq(1'b0, 32'h0, 1'b0);
        look();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_after_valid", 64'(deq_valid), 64'd0);
        cyc();
        set_enq(1'b1, 32'h4000, 1'b0);
        cyc();
        set_enq(1'b0, 32'h0, 1'b0);
        look();
        chk("flush_new_pc", 64'(deq_pc), 64'h4000);
        cyc();
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        look();
        chk("flush_got_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("flush_got_pc", 64'(got[0][31:0]), 64'h4000);

        // Fault propagation
        got.delete();
        cyc(); set_enq(1'b1, 32'h4FFC, 1'b0);
        cyc(); set_enq(1'b1, 32'h5000, 1'b1);
        cyc(); set_enq(1'b1, 32'h5004, 1'b0);
        cyc(); set_enq(1'b0, 32'h0, 1'b0);
        deq_ready = 1'b1;
        repeat (3) cyc();
        deq_ready = 1'b0;
        look();
        chk("fault_n", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("fault_0", 64'(got[0]), {31'd0, 1'b0, 32'h4FFC});
            chk("fault_1", 64'(got[1]), {31'd0, 1'b1, 32'h5000});
            chk("fault_2", 64'(got[2]), {31'd0, 1'b0, 32'h5004});
        end

        // Reset mid-stream
        got.delete();
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_enq(1'b1, 32'h8000 + 32'(4 * k), 1'b0);
        end
        cyc();
        set_enq(1'b1, 32'h9000, 1'b0);
        rst = 1'b1;
        deq_ready = 1'b1;
        look();
        chk("mrst_pre_count", 64'(count), 64'd4);
        chk("mrst_enq_ready", 64'(enq_ready), 64'd0);
        chk("mrst_deq_valid", 64'(deq_valid), 64'd0);
        cyc();
        rst = 1'b0;
        deq_ready = 1'b0;
        set_enq(1'b0, 32'h0, 1'b0);
        look();
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_valid", 64'(deq_valid), 64'd0);
        cyc(); set_enq(1'b1, 32'hA000, 1'b0);
        cyc(); set_enq(1'b0, 32'h0, 1'b0);
        deq_ready = 1'b1;
        repeat (2) cyc();
        deq_ready = 1'b0;
        look();
        chk("mrst_got_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("mrst_got_pc", 64'(got[0][31:0]), 64'hA000);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
